matriz_unaria_seq: RTL

Parametrised, sequential unary-matrix unit for the coprocessor ULA: negation, scalar multiply, transpose and copy of an N×N matrix of signed W-bit elements. It takes a start/done handshake and processes LANES elements per clock, so area can be traded against latency. With the default parameters (N=5, W=8) the packed buses are 200 bits wide, the same as the other ULA operand buses, so it slots in as the multi-cycle successor of the combinational opposite-matrix operator.

---
 rtl/matriz_pkg.sv | 19 +
 rtl/matriz_elem_op.sv | 72 +++++++
 rtl/matriz_unaria_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/matriz_pkg.sv
// matriz_pkg: shared definitions for the sequential unary-matrix unit.
//   op_t    : operation codes (oposta, escalar, transposta, copia)
//   state_t : control FSM states
package matriz_pkg;

    typedef enum logic [1:0] {
        OP_OPOSTA     = 2'd0,
        OP_ESCALAR    = 2'd1,
        OP_TRANSPOSTA = 2'd2,
        OP_COPIA      = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matriz_elem_op.sv
// matriz_elem_op: combinational per-element operation.
//   i_op   : operation (negate, multiply by scalar, pass-through)
//   i_a    : signed source element
//   i_esc  : signed scalar
//   o_res  : W-bit result (wrapped, or saturated with MATRIZ_SAT_EN)
//   o_clip : result was clipped (always 0 unless MATRIZ_SAT_EN is defined)
// Config macro: MATRIZ_SAT_EN enables saturation of negate/multiply.
module matriz_elem_op
    import matriz_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  op_t                 i_op,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_esc,
    output logic [W-1:0]        o_res,
    output logic                o_clip
);

`ifdef MATRIZ_SAT_EN
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0]     w_neg;
    logic signed [2*W-1:0] w_prod;

    // One extra bit is enough to hold -(-2^(W-1)).
    assign w_neg  = -{i_a[W-1], i_a};
    assign w_prod = i_a * i_esc;

    always_comb begin
        o_res  = i_a;
        o_clip = 1'b0;
        case (i_op)
            OP_OPOSTA: begin
                o_res = w_neg[W-1:0];
                if (w_neg[W] != w_neg[W-1]) begin
                    o_clip = 1'b1;
                    o_res  = w_neg[W] ? MINV : MAXV;
                end
            end
            OP_ESCALAR: begin
                o_res = w_prod[W-1:0];
                // Fits in W bits only if the upper W+1 bits are pure sign.
                if ((w_prod[2*W-1:W-1] != '0) && (w_prod[2*W-1:W-1] != '1)) begin
                    o_clip = 1'b1;
                    o_res  = w_prod[2*W-1] ? MINV : MAXV;
                end
            end
            default: ;
        endcase
    end
`else
    logic [W-1:0] w_neg;
    logic [W-1:0] w_prod;

    // Low W bits of the negation / product are the modulo-2^W result.
    assign w_neg  = -i_a;
    assign w_prod = i_a * i_esc;

    always_comb begin
        o_res  = i_a;
        o_clip = 1'b0;
        case (i_op)
            OP_OPOSTA:  o_res = w_neg;
            OP_ESCALAR: o_res = w_prod;
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/matriz_unaria_seq.sv
// matriz_unaria_seq: sequential unary operation on an N x N signed matrix,
// LANES elements per clock, start/done handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request, sampled when not busy
//   op                : 0 oposta, 1 escalar, 2 transposta, 3 copia
//   escalar           : signed scalar for op 1
//   matrizA           : operand, element (r,c) at [(r*N+c)*W +: W]
//   matriz_resultante : result register, same packing
//   busy / done       : processing / one-cycle completion pulse
//   overflow          : sticky clip flag for the current operation
// Config macro: MATRIZ_SAT_EN (saturation + overflow); otherwise wrap and
// overflow stays 0.
module matriz_unaria_seq
    import matriz_pkg::*;
#(
    parameter int unsigned N     = 5,
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [W-1:0]     escalar,
    input  logic [N*N*W-1:0] matrizA,
    output logic [N*N*W-1:0] matriz_resultante,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned NE = N * N;
    localparam int unsigned IW = $clog2(NE + LANES + 1);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [NE*W-1:0] r_a;
    logic [NE*W-1:0] r_res;
    op_t             r_op;
    logic [W-1:0]    r_esc;
    logic            r_busy;
    logic            r_done;
    logic            r_ovf;

    logic [LANES-1:0][IW-1:0] w_lane_e;
    logic [LANES-1:0][W-1:0]  w_lane_res;
    logic [LANES-1:0]         w_lane_en;
    logic [LANES-1:0]         w_lane_clip;
    logic                     w_any_clip;
    logic                     w_last;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW-1:0] w_e;
        logic [IW-1:0] w_src;

        assign w_e          = r_idx + IW'(l);
        assign w_lane_e[l]  = w_e;
        assign w_lane_en[l] = (w_e < IW'(NE));

        // Disabled lanes read element 0 so the select stays in range.
        always_comb begin
            w_src = w_e;
            if (!w_lane_en[l]) begin
                w_src = '0;
            end else if (r_op == OP_TRANSPOSTA) begin
                w_src = IW'((32'(w_e) % N) * N + 32'(w_e) / N);
            end
        end

        matriz_elem_op #(.W(W)) u_elem (
            .i_op   (r_op),
            .i_a    (r_a[w_src*W +: W]),
            .i_esc  (r_esc),
            .o_res  (w_lane_res[l]),
            .o_clip (w_lane_clip[l])
        );
    end

    assign w_any_clip = |(w_lane_clip & w_lane_en);
    assign w_last     = ((32'(r_idx) + LANES) >= NE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_op    <= OP_OPOSTA;
            r_esc   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= matrizA;
                        r_op    <= op_t'(op);
                        r_esc   <= escalar;
                        r_idx   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= PROC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PROC: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (w_lane_en[l]) begin
                            r_res[w_lane_e[l]*W +: W] <= w_lane_res[l];
                        end
                    end
                    r_ovf <= r_ovf | w_any_clip;
                    r_idx <= r_idx + IW'(LANES);
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign matriz_resultante = r_res;
    assign busy              = r_busy;
    assign done              = r_done;
    assign overflow          = r_ovf;

endmodule
